aes_mix_columns_iter: RTL and testbench
=======================================

# aes_mix_columns_iter

Parametrised, handshaked MixColumns engine for the AES-128 datapath. It accepts a 128-bit state and transforms COLS_PER_CYCLE columns per clock over 4/COLS_PER_CYCLE cycles, trading area for latency. With the inverse option compiled in, it also performs InvMixColumns, so the encrypt and decrypt round pipelines share one block. It sits between ShiftRows/InvShiftRows and AddRoundKey, and uses valid/ready handshakes on both sides.

## Interface
- COLS_PER_CYCLE, default 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  data_in and inverse are valid
- in_ready  out  1  block can accept a new state
- data_in  in  128  input state; column c = bits [127-32c -: 32], row 0 is the MSB byte of the column
- inverse  in  1  1 = InvMixColumns, 0 = MixColumns; sampled on accept
- out_valid  out  1  data_out holds a completed result
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  result state, same byte mapping as data_in
- busy  out  1  high in BUSY and HOLD

## Operation
- FSM states:
  - IDLE: in_ready=1. If in_valid, load data_in into the working register, latch inverse, set cnt=0, go to BUSY.
  - BUSY: each cycle transforms columns cnt*COLS_PER_CYCLE through cnt*COLS_PER_CYCLE+COLS_PER_CYCLE-1 in place, then increments cnt. The last group (cnt==4/COLS_PER_CYCLE-1) goes to HOLD and sets out_valid.
  - HOLD: out_valid=1, data_out stable. If out_ready, clear out_valid and go to IDLE.
- Forward matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
- Inverse matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
- GF(2^8) arithmetic uses polynomial 0x11B. xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0). Higher multiples are built from xtime and XOR; no multiplier inference.
- data_out is driven directly from the working register.
- in_ready is low outside IDLE, and in_valid is ignored there. data_in may change freely after the accept edge.
- The mode is latched per block, so toggling inverse during BUSY has no effect.
- out_ready while not in HOLD is ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, data_out=128'h0, state=IDLE, cnt=0.
- Reset is asynchronous. Asserting it mid-BUSY or in HOLD aborts the block immediately, and the partial result is discarded.
- Latency: out_valid rises exactly N=4/COLS_PER_CYCLE cycles after the accept edge (4, 2 or 1 cycles).
- in_ready rises the cycle after the HOLD→IDLE edge. Minimum block period is N+2 cycles when out_ready is held high.
- Backpressure: HOLD persists indefinitely while out_ready=0, with data_out unchanged.
- cnt width is 2 bits and it never wraps in BUSY. The exit is decided on the last group.

## Configuration
- MIXCOL_INV_EN defined: the inverse datapath is built and the inverse input selects the mode as described.
- MIXCOL_INV_EN undefined:
  - The inverse port remains present but is ignored.
  - Only the forward matrix is built.
  - Inverse-mode requests return the forward result.

## Structure
- Shared package aes_pkg holds:
  - functions xtime, gmul2, gmul3, gmul9, gmul11, gmul13, gmul14
  - constant AES_NUM_COLS=4
  - state enum for IDLE/BUSY/HOLD
- Sub-module aes_mix_word is a combinational transform of one 32-bit column with an inverse select. It is instantiated COLS_PER_CYCLE times, and a generate block steers the column selection.

## Test plan
- Forward FIPS-197 columns: state d4bf5d30_db135345_f20a225c_01010101, inverse=0 → data_out 046681e5_8e4da1bc_9fdc589d_01010101.
- Inverse (MIXCOL_INV_EN): state 046681e5_8e4da1bc_9fdc589d_c6c6c6c6, inverse=1 → d4bf5d30_db135345_f20a225c_c6c6c6c6. Without the macro, the same stimulus returns the forward result.
- Latency sweep: COLS_PER_CYCLE=1/2/4 → out_valid exactly 4/2/1 cycles after accept. in_ready stays 0 from accept until the cycle after the out handshake.
- Backpressure: out_ready=0 for 10 cycles → out_valid held, data_out constant, a second in_valid is not accepted. Raising out_ready completes the transfer and in_ready=1 on the next cycle.
- Reset mid-BUSY (COLS_PER_CYCLE=1, assert reset_n=0 two cycles after accept) → out_valid=0, data_out=0, in_ready=1 immediately. The next block then produces the correct result.
- Back-to-back: 100 random states with random valid/ready gaps, checked against a reference model. No lost or duplicated results, and the mode is honoured per block.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, column count and FSM state encoding for the MixColumns engine
package aes_pkg;
  localparam int AES_NUM_COLS = 4;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return xtime(x);
  endfunction
  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction
  function automatic logic [7:0] gmul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction
  function automatic logic [7:0] gmul11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction
  function automatic logic [7:0] gmul13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction
  function automatic logic [7:0] gmul14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
endpackage

// File: rtl/aes_mix_word.sv
// aes_mix_word: combinational (Inv)MixColumns of one 32-bit column; inverse matrix only built with MIXCOL_INV_EN
module aes_mix_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  input  logic        inv,
  output logic [31:0] y
);
  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd;
  assign {a0, a1, a2, a3} = w;
  assign fwd = {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
                a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
`ifdef MIXCOL_INV_EN
  logic [31:0] bwd;
  assign bwd = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3)};
  assign y = inv ? bwd : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign y = fwd;
`endif
endmodule

// File: rtl/aes_mix_columns_iter.sv
// aes_mix_columns_iter: handshaked iterative MixColumns, COLS_PER_CYCLE columns per clock; MIXCOL_INV_EN adds InvMixColumns
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int N = AES_NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(N - 1);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t state;
  logic [1:0] cnt;
  logic mode;
  logic [127:0] st, nxt;
  logic [31:0] cols [AES_NUM_COLS];
  logic [31:0] win [COLS_PER_CYCLE];
  logic [31:0] res [COLS_PER_CYCLE];
  assign data_out = st;
  for (genvar c = 0; c < AES_NUM_COLS; c++) begin : g_col
    assign cols[c] = st[127-32*c -: 32];
    assign nxt[127-32*c -: 32] = (cnt == 2'(c / COLS_PER_CYCLE)) ? res[c % COLS_PER_CYCLE] : cols[c];
  end
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_word
    assign win[g] = cols[2'(int'(cnt) * COLS_PER_CYCLE + g)];
    aes_mix_word u_word (.w(win[g]), .inv(mode), .y(res[g]));
  end
  // Control FSM and working register; the current column group is transformed in place each BUSY cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      mode      <= 1'b0;
      st        <= 128'h0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st       <= data_in;
          mode     <= inverse;
          cnt      <= 2'd0;
          state    <= BUSY;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        BUSY: begin
          st  <= nxt;
          cnt <= (cnt == LAST) ? 2'd0 : cnt + 2'd1;
          if (cnt == LAST) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// tb_aes_mix_columns_iter: directed and random checks of COLS_PER_CYCLE=1/2/4 against a generic GF(2^8) matrix model
module tb_aes_mix_columns_iter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic iv [3];
  logic ir [3];
  logic [127:0] din [3];
  logic inv [3];
  logic ov [3];
  logic ordy [3];
  logic [127:0] dout [3];
  logic bsy [3];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(iv[g]), .in_ready(ir[g]), .data_in(din[g]),
      .inverse(inv[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .data_out(dout[g]), .busy(bsy[g])
    );
  end
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic m);
    logic [7:0] row0 [4];
    logic [7:0] o;
    logic [127:0] r;
    row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
`ifdef MIXCOL_INV_EN
    if (m) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
`endif
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o ^= gm(row0[(k - rr + 4) % 4], s[127-32*c-8*k -: 8]);
        r[127-32*c-8*rr -: 8] = o;
      end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic xfer(input int k, input logic [127:0] d, input logic m, input logic [127:0] e, input int hold);
    int lat;
    logic irlow;
    chk("in_ready_idle", 128'(ir[k]), 128'(1));
    iv[k] = 1'b1; din[k] = d; inv[k] = m;
    @(negedge clk);
    iv[k] = 1'b0; din[k] = rnd128(); inv[k] = ~m;
    irlow = 1'b1;
    lat = 0;
    while (!ov[k] && lat < 20) begin
      irlow &= ~ir[k];
      @(negedge clk);
      lat++;
    end
    irlow &= ~ir[k];
    chk("latency", 128'(lat), 128'(4 / (1 << k)));
    chk("in_ready_low", 128'(irlow), 128'(1));
    chk("busy_hold", 128'(bsy[k]), 128'(1));
    chk("data_out", dout[k], e);
    for (int h = 0; h < hold; h++) begin
      iv[k] = 1'b1; din[k] = rnd128();
      @(negedge clk);
      chk("bp_out_valid", 128'(ov[k]), 128'(1));
      chk("bp_data_out", dout[k], e);
      chk("bp_in_ready", 128'(ir[k]), 128'(0));
    end
    iv[k] = 1'b0; ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk("done_out_valid", 128'(ov[k]), 128'(0));
    chk("done_in_ready", 128'(ir[k]), 128'(1));
    chk("done_busy", 128'(bsy[k]), 128'(0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] d, e;
    logic m;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; din[k] = '0; inv[k] = 1'b0; ordy[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 128'(ir[k]), 128'(1));
      chk("rst_out_valid", 128'(ov[k]), 128'(0));
      chk("rst_busy", 128'(bsy[k]), 128'(0));
      chk("rst_data_out", dout[k], 128'h0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      xfer(k, 128'hd4bf5d30_db135345_f20a225c_01010101, 1'b0, 128'h046681e5_8e4da1bc_9fdc589d_01010101, 0);
    d = 128'h046681e5_8e4da1bc_9fdc589d_c6c6c6c6;
`ifdef MIXCOL_INV_EN
    e = 128'hd4bf5d30_db135345_f20a225c_c6c6c6c6;
`else
    e = ref_mix(d, 1'b0);
`endif
    for (int k = 0; k < 3; k++) xfer(k, d, 1'b1, e, 0);
    xfer(0, 128'hd4bf5d30_db135345_f20a225c_01010101, 1'b0, 128'h046681e5_8e4da1bc_9fdc589d_01010101, 10);
    @(negedge clk);
    chk("no_second_accept", 128'(bsy[0]), 128'(0));
    iv[0] = 1'b1; din[0] = 128'hd4bf5d30_db135345_f20a225c_01010101; inv[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 128'(bsy[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(ov[0]), 128'(0));
    chk("abort_data_out", dout[0], 128'h0);
    chk("abort_in_ready", 128'(ir[0]), 128'(1));
    chk("abort_busy", 128'(bsy[0]), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xfer(0, 128'hd4bf5d30_db135345_f20a225c_01010101, 1'b0, 128'h046681e5_8e4da1bc_9fdc589d_01010101, 0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 100; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        d = rnd128();
        m = 1'($urandom_range(0, 1));
        xfer(k, d, m, ref_mix(d, m), $urandom_range(0, 3));
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
